// File: rtl/fetch_queue.sv
// fetch_queue: receiving end of the fetch interface.
// Holds {pc, instruction} pairs from fetch and hands them to decode in order
// over a valid/ready handshake. freeze_if holds fetch while the queue is full;
// flush (taken branch) discards every queued entry.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a word
// arriving at an empty queue is shown to decode in the same cycle.
module fetch_queue #(
  parameter int BIT_NUMBER = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [BIT_NUMBER-1:0] if_pc,
  input  logic [BIT_NUMBER-1:0] if_instruction,
  output logic                  freeze_if,
  input  logic                  id_ready,
  output logic                  id_valid,
  output logic [BIT_NUMBER-1:0] id_pc,
  output logic [BIT_NUMBER-1:0] id_instruction,
  output logic [PTR_W:0]        occupancy
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [BIT_NUMBER-1:0] pc_mem_q    [DEPTH];
  logic [BIT_NUMBER-1:0] instr_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic head_valid;
  logic consume_bypass;
  logic push;
  logic pop;

  // Full flag comes from the registered count only, so it never depends on id_ready.
  assign freeze_if  = (count_q == FULL_CNT);
  assign head_valid = (count_q != '0);
  assign occupancy  = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_hit;

  // Empty queue and no branch: the incoming word goes straight to decode.
  assign bypass_hit     = !rst && !flush && !head_valid;
  assign consume_bypass = bypass_hit && id_ready;

  // Head entry when present, otherwise the bypassed fetch word, otherwise zero.
  always_comb begin
    id_valid       = head_valid || bypass_hit;
    id_pc          = '0;
    id_instruction = '0;
    if (head_valid) begin
      id_pc          = pc_mem_q[rd_ptr_q];
      id_instruction = instr_mem_q[rd_ptr_q];
    end else if (bypass_hit) begin
      id_pc          = if_pc;
      id_instruction = if_instruction;
    end
  end
`else
  assign consume_bypass = 1'b0;

  // Head entry gated to zero while the queue is empty.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    id_valid       = head_valid;
    id_pc          = '0;
    id_instruction = '0;
    if (head_valid) begin
      id_pc          = pc_mem_q[rd_ptr_q];
      id_instruction = instr_mem_q[rd_ptr_q];
    end
  end
`endif

  // Fetch advances on every unfrozen cycle, so a word is captured on each of them
  // unless a branch is redirecting fetch or the word was consumed by the bypass.
  assign push = !freeze_if && !flush && !consume_bypass;
  assign pop  = head_valid && id_ready && !flush;

  // Pointer and count next state; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; id_valid gating hides stale contents.
    if (push && !rst) begin
      pc_mem_q[wr_ptr_q]    <= if_pc;
      instr_mem_q[wr_ptr_q] <= if_instruction;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4).
// A queue-based model of the fetch queue is compared against the DUT on every
// falling edge; directed steps also pin hand-computed literal values.
module tb_fetch_queue;

  localparam int BW    = 32;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [BW-1:0] if_pc;
  logic [BW-1:0] if_instruction;
  logic          freeze_if;
  logic          id_ready;
  logic          id_valid;
  logic [BW-1:0] id_pc;
  logic [BW-1:0] id_instruction;
  logic [2:0]    occupancy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model contents: {pc, instruction}, head at index 0.
  logic [63:0] mq[$];

  fetch_queue #(.BIT_NUMBER(BW), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .freeze_if      (freeze_if),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] instr_of(input logic [BW-1:0] pc);
    return pc ^ 32'hA5A5_0F0F;
  endfunction

  task automatic drive(input bit r, input bit f, input logic [BW-1:0] pc, input bit rdy);
    rst            = r;
    flush          = f;
    if_pc          = pc;
    if_instruction = instr_of(pc);
    id_ready       = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_bypass();
    return BYP && !rst && !flush && (mq.size() == 0);
  endfunction

  // Model state update on each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (rst || flush) begin
      mq.delete();
    end else begin
      bit full, byp_take;
      full     = (mq.size() == DEPTH);
      byp_take = model_bypass() && id_ready;
      if (mq.size() != 0 && id_ready) void'(mq.pop_front());
      if (!full && !byp_take) mq.push_back({if_pc, if_instruction});
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      logic [BW-1:0] e_pc, e_in;
      bit            e_v;
      e_v  = (mq.size() != 0) || model_bypass();
      e_pc = '0;
      e_in = '0;
      if (mq.size() != 0) begin
        e_pc = mq[0][63:32];
        e_in = mq[0][31:0];
      end else if (model_bypass()) begin
        e_pc = if_pc;
        e_in = if_instruction;
      end
      check("model_id_valid",  64'(id_valid),       64'(e_v));
      check("model_id_pc",     64'(id_pc),          64'(e_pc));
      check("model_id_instr",  64'(id_instruction), 64'(e_in));
      check("model_occupancy", 64'(occupancy),      64'(mq.size()));
      check("model_freeze_if", 64'(freeze_if),      64'(mq.size() == DEPTH));
    end
  end

  initial begin
    // Reset held for two edges with a live fetch word.
    drive(1, 0, 32'h4, 0);
    tick();
    tick();
    check("rst_occupancy", 64'(occupancy),      64'd0);
    check("rst_id_valid",  64'(id_valid),       64'd0);
    check("rst_id_pc",     64'(id_pc),          64'd0);
    check("rst_id_instr",  64'(id_instruction), 64'd0);
    check("rst_freeze_if", 64'(freeze_if),      64'd0);

    // First cycle out of reset: still empty, word 4 captured at the next edge.
    drive(0, 0, 32'h4, 0);
    #1;
    check("post_rst_occ0", 64'(occupancy), 64'd0);
    tick();
    check("post_rst_occ1", 64'(occupancy), 64'd1);
    check("first_id_pc",   64'(id_pc),     64'h4);
    check("first_id_instr", 64'(id_instruction), 64'(instr_of(32'h4)));

    // Fill to DEPTH with decode stalled.
    for (int k = 2; k <= 4; k++) begin
      drive(0, 0, BW'(4 * k), 0);
      tick();
    end
    check("full_occupancy", 64'(occupancy), 64'd4);
    check("full_freeze_if", 64'(freeze_if), 64'd1);
    check("full_id_pc",     64'(id_pc),     64'h4);

    // Fifth word presented while frozen is not stored.
    drive(0, 0, 32'h14, 0);
    tick();
    check("frozen_occupancy", 64'(occupancy), 64'd4);
    check("frozen_id_pc",     64'(id_pc),     64'h4);

    // Pop from full: no push in the same cycle, freeze drops afterwards.
    drive(0, 0, 32'h14, 1);
    tick();
    check("pop_full_id_pc",  64'(id_pc),     64'h8);
    check("pop_full_occ",    64'(occupancy), 64'd3);
    check("pop_full_freeze", 64'(freeze_if), 64'd0);

    // Word 20 now pushed while 8 is popped.
    drive(0, 0, 32'h14, 1);
    tick();
    check("push20_occ",   64'(occupancy), 64'd3);
    check("push20_id_pc", 64'(id_pc),     64'hC);

    // Taken branch at occupancy 3 discards everything including 0x100.
    drive(0, 1, 32'h100, 1);
    tick();
    check("flush_occ",      64'(occupancy), 64'd0);
    check("flush_id_valid", 64'(id_valid),  64'd0);

    // Steady stream with decode always ready; pointers wrap several times.
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, BW'(32'h200 + 4 * k), 1);
      tick();
      check("stream_occ",   64'(occupancy), BYP ? 64'd0 : 64'd1);
      check("stream_id_pc", 64'(id_pc),     64'(32'h200 + 4 * k));
    end

    // Reset mid-stream drops queued entries.
    drive(0, 0, 32'h300, 0);
    tick();
    tick();
    drive(1, 0, 32'h308, 0);
    tick();
    check("midrst_occ",      64'(occupancy), 64'd0);
    check("midrst_id_valid", 64'(id_valid),  64'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Zero-latency pass-through into an empty queue, consumed without a push.
    drive(0, 0, 32'h40, 1);
    #1;
    check("bypass_id_valid", 64'(id_valid), 64'd1);
    check("bypass_id_pc",    64'(id_pc),    64'h40);
    tick();
    check("bypass_occ",      64'(occupancy), 64'd0);
`endif

    drive(1, 0, 32'h0, 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
